// File: rtl/uart_host_bridge.sv
// uart_host_bridge
//   Byte-stream front end for top_module_UART. Accepts transmit bytes on a
//   valid/ready input and writes them into the UART: data register 0 first,
//   then the control send bit. It polls the control register. When the UART
//   reports a received byte (new_rx), the bridge reads it from data
//   register 1, clears new_rx and offers the byte on a valid/ready output.
//
// Ports
//   clk_10MHz        system clock; all logic updates on the rising edge
//   rst              synchronous, active-low reset
//   tx_data_i/_valid_i/_ready_o   transmit byte handshake (ready is a 1-cycle pulse)
//   rx_data_o/_valid_o/rx_ready_i receive byte handshake (valid held until ready)
//   uart_wr_po       UART register write strobe
//   uart_reg_sel_po  1 = data registers, 0 = control register
//   uart_addr_po     data register index: 0 = TX, 1 = RX
//   uart_input_po    UART write data
//   uart_output_pi   UART read data; combinational from the addressed register
//   timeout_o        sticky flag: a send did not finish within TIMEOUT_CYC cycles
//
// Control register: bit0 = send (set by writing 0x01, cleared by the UART at
// frame end). bit1 = new_rx (set by the UART, cleared by writing 0).

module uart_host_bridge #(
   parameter int unsigned POLL_GAP    = 4,
   parameter int unsigned TIMEOUT_CYC = 20000
) (
   input  logic       clk_10MHz,
   input  logic       rst,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   input  logic       rx_ready_i,
   output logic       uart_wr_po,
   output logic       uart_reg_sel_po,
   output logic       uart_addr_po,
   output logic [7:0] uart_input_po,
   input  logic [7:0] uart_output_pi,
   output logic       timeout_o
);

   localparam int unsigned PW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

   typedef enum logic [3:0] {
      S_IDLE,
      S_POLL,
      S_READY,
      S_WR_DATA,
      S_WR_SEND,
      S_WAIT_SEND,
      S_RD_RX,
      S_CLR_RX,
      S_PUSH_RX
   } state_t;

   state_t          state, state_nx;
   logic [PW-1:0]   poll_cnt, poll_cnt_nx;
   logic [TW-1:0]   tmo_cnt, tmo_cnt_nx;
   logic            rx_pending, rx_pending_nx;
   logic [7:0]      tx_byte, tx_byte_nx;
   logic            timeout_nx;
   logic [7:0]      rx_data_nx;
   logic            wr_nx, sel_nx, addr_nx;
   logic [7:0]      din_nx;
   logic            tx_ready_nx, rx_valid_nx;
   logic            poll_last;
   logic            ctrl_send, ctrl_new_rx;

   assign poll_last   = (poll_cnt == PW'(POLL_GAP - 1));
   assign ctrl_send   = uart_output_pi[0];
   assign ctrl_new_rx = uart_output_pi[1];

   always_ff @(posedge clk_10MHz) begin
      if (!rst) begin
         state           <= S_IDLE;
         poll_cnt        <= '0;
         tmo_cnt         <= '0;
         rx_pending      <= 1'b0;
         tx_byte         <= '0;
         timeout_o       <= 1'b0;
         rx_data_o       <= '0;
         uart_wr_po      <= 1'b0;
         uart_reg_sel_po <= 1'b0;
         uart_addr_po    <= 1'b0;
         uart_input_po   <= '0;
         tx_ready_o      <= 1'b0;
         rx_valid_o      <= 1'b0;
      end else begin
         state           <= state_nx;
         poll_cnt        <= poll_cnt_nx;
         tmo_cnt         <= tmo_cnt_nx;
         rx_pending      <= rx_pending_nx;
         tx_byte         <= tx_byte_nx;
         timeout_o       <= timeout_nx;
         rx_data_o       <= rx_data_nx;
         uart_wr_po      <= wr_nx;
         uart_reg_sel_po <= sel_nx;
         uart_addr_po    <= addr_nx;
         uart_input_po   <= din_nx;
         tx_ready_o      <= tx_ready_nx;
         rx_valid_o      <= rx_valid_nx;
      end
   end

   always_comb begin
      state_nx      = state;
      poll_cnt_nx   = '0;
      tmo_cnt_nx    = tmo_cnt;
      rx_pending_nx = rx_pending;
      tx_byte_nx    = tx_byte;
      timeout_nx    = timeout_o;
      rx_data_nx    = rx_data_o;

      case (state)
         S_IDLE: begin
            if (poll_last) begin
               state_nx = S_POLL;
            end else begin
               poll_cnt_nx = poll_cnt + 1'b1;
            end
         end

         // A ctrl read looks like an idle bus (sel=0, addr=0); the value is
         // taken at the edge that closes this cycle.
         S_POLL: begin
            if (ctrl_new_rx || rx_pending) begin
               state_nx = S_RD_RX;
            end else if (!ctrl_send) begin
               state_nx = S_READY;
            end else begin
               state_nx = S_IDLE;
            end
         end

         S_READY: begin
            if (tx_valid_i) begin
               tx_byte_nx = tx_data_i;
               state_nx   = S_WR_DATA;
            end else begin
               state_nx = S_IDLE;
            end
         end

         S_WR_DATA: state_nx = S_WR_SEND;

         S_WR_SEND: begin
            tmo_cnt_nx = '0;
            state_nx   = S_WAIT_SEND;
         end

         S_WAIT_SEND: begin
            poll_cnt_nx = poll_last ? '0 : poll_cnt + 1'b1;
            if (tmo_cnt != TW'(TIMEOUT_CYC)) begin
               tmo_cnt_nx = tmo_cnt + 1'b1;
            end
            // new_rx cannot be cleared while send is busy, so remember it and
            // service it once the frame has gone out.
            if (poll_last) begin
               if (ctrl_new_rx) begin
                  rx_pending_nx = 1'b1;
               end
               if (!ctrl_send) begin
                  state_nx = (rx_pending || ctrl_new_rx) ? S_RD_RX : S_IDLE;
               end
            end
            // A completed send seen on the same cycle takes precedence.
            if ((state_nx == S_WAIT_SEND) && (tmo_cnt == TW'(TIMEOUT_CYC))) begin
               timeout_nx = 1'b1;
               state_nx   = S_IDLE;
            end
         end

         S_RD_RX: begin
            rx_data_nx = uart_output_pi;
            state_nx   = S_CLR_RX;
         end

         S_CLR_RX: begin
            rx_pending_nx = 1'b0;
            state_nx      = S_PUSH_RX;
         end

         S_PUSH_RX: begin
            if (rx_ready_i) begin
               state_nx = S_IDLE;
            end
         end

         default: state_nx = S_IDLE;
      endcase
   end

   // Outputs are registered, so the bus values for a state are decoded from
   // the state being entered and appear during that state's cycle.
   always_comb begin
      wr_nx       = 1'b0;
      sel_nx      = 1'b0;
      addr_nx     = 1'b0;
      din_nx      = '0;
      tx_ready_nx = 1'b0;
      rx_valid_nx = 1'b0;

      case (state_nx)
         S_READY:   tx_ready_nx = 1'b1;
         S_WR_DATA: begin
            wr_nx  = 1'b1;
            sel_nx = 1'b1;
            din_nx = tx_byte_nx;
         end
         S_WR_SEND: begin
            wr_nx  = 1'b1;
            din_nx = 8'h01;
         end
         S_RD_RX: begin
            sel_nx  = 1'b1;
            addr_nx = 1'b1;
         end
         S_CLR_RX:  wr_nx = 1'b1;
         S_PUSH_RX: rx_valid_nx = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_uart_host_bridge.sv
// tb_uart_host_bridge
//   Bench for uart_host_bridge against a small behavioural model of the UART
//   register file. The model can loop TX back to RX at frame end, inject an
//   RX byte, or hold send stuck high.

module tb_uart_host_bridge;

   localparam int unsigned POLL_GAP    = 4;
   localparam int unsigned TIMEOUT_CYC = 64;
   localparam int unsigned FRAME       = 30;

   logic       clk_10MHz = 1'b0;
   logic       rst;
   logic [7:0] tx_data_i;
   logic       tx_valid_i;
   logic       tx_ready_o;
   logic [7:0] rx_data_o;
   logic       rx_valid_o;
   logic       rx_ready_i;
   logic       uart_wr_po;
   logic       uart_reg_sel_po;
   logic       uart_addr_po;
   logic [7:0] uart_input_po;
   logic [7:0] uart_output_pi;
   logic       timeout_o;

   uart_host_bridge #(
      .POLL_GAP   (POLL_GAP),
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk_10MHz      (clk_10MHz),
      .rst            (rst),
      .tx_data_i      (tx_data_i),
      .tx_valid_i     (tx_valid_i),
      .tx_ready_o     (tx_ready_o),
      .rx_data_o      (rx_data_o),
      .rx_valid_o     (rx_valid_o),
      .rx_ready_i     (rx_ready_i),
      .uart_wr_po     (uart_wr_po),
      .uart_reg_sel_po(uart_reg_sel_po),
      .uart_addr_po   (uart_addr_po),
      .uart_input_po  (uart_input_po),
      .uart_output_pi (uart_output_pi),
      .timeout_o      (timeout_o)
   );

   always #50 clk_10MHz = ~clk_10MHz;

   // ---------------- UART register model ----------------
   logic        u_send, u_new_rx;
   logic [7:0]  u_d0, u_d1;
   int unsigned u_fcnt;
   logic        stuck, loopback, inj_req;
   logic [7:0]  inj_byte;

   assign uart_output_pi = uart_reg_sel_po ? (uart_addr_po ? u_d1 : u_d0)
                                           : {6'b0, u_new_rx, u_send};

   always @(posedge clk_10MHz) begin
      if (!rst) begin
         u_send   <= 1'b0;
         u_new_rx <= 1'b0;
         u_d0     <= 8'h00;
         u_d1     <= 8'h00;
         u_fcnt   <= 0;
      end else begin
         if (uart_wr_po) begin
            if (uart_reg_sel_po) begin
               if (!uart_addr_po) u_d0 <= uart_input_po;
            end else begin
               if (uart_input_po[0]) begin
                  u_send <= 1'b1;
                  u_fcnt <= 0;
               end
               u_new_rx <= uart_input_po[1];
            end
         end else if (u_send) begin
            if (u_fcnt >= FRAME && !stuck) begin
               u_send <= 1'b0;
               if (loopback) begin
                  u_d1     <= u_d0;
                  u_new_rx <= 1'b1;
               end
            end else begin
               u_fcnt <= u_fcnt + 1;
            end
         end
         if (inj_req) begin
            u_d1     <= inj_byte;
            u_new_rx <= 1'b1;
         end
      end
   end

   // ---------------- checking ----------------
   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   int unsigned cyc = 0;
   always @(posedge clk_10MHz) cyc++;

   logic [9:0]  wq[$];      // expected bus writes {sel, addr, data}
   logic [7:0]  rq[$];      // expected received bytes
   logic [9:0]  exp_w;
   logic [7:0]  exp_r;
   int unsigned last_data_cyc = 0;
   int unsigned last_send_cyc = 0;
   logic        saw_send_wr = 1'b0;

   function automatic logic [20:0] outs();
      return {tx_ready_o, rx_valid_o, uart_wr_po, uart_reg_sel_po, uart_addr_po,
              uart_input_po, rx_data_o, timeout_o};
   endfunction

   always @(negedge clk_10MHz) begin
      if (rst) begin
         if (uart_wr_po) begin
            if (wq.size() == 0) begin
               check_eq("wr_unexpected", 32'({1'b1, uart_reg_sel_po, uart_addr_po, uart_input_po}), 32'd0);
            end else begin
               exp_w = wq.pop_front();
               check_eq("wr_bus", 32'({uart_reg_sel_po, uart_addr_po, uart_input_po}), 32'(exp_w));
            end
            if (uart_reg_sel_po && !uart_addr_po) last_data_cyc = cyc;
            if (!uart_reg_sel_po && uart_input_po == 8'h01) begin
               check_eq("send_follows_data", cyc - last_data_cyc, 32'd1);
               last_send_cyc = cyc;
               saw_send_wr   = 1'b1;
            end
         end
         if (tx_valid_i && tx_ready_o) begin
            wq.push_back({1'b1, 1'b0, tx_data_i});
            wq.push_back({2'b00, 8'h01});
            if (loopback) begin
               wq.push_back(10'h000);
               rq.push_back(tx_data_i);
            end
         end
         if (rx_valid_o) begin
            check_eq("push_quiet", 32'({uart_wr_po, tx_ready_o, uart_reg_sel_po, uart_addr_po}), 32'd0);
         end
         if (rx_valid_o && rx_ready_i) begin
            if (rq.size() == 0) begin
               check_eq("rx_unexpected", 32'({1'b1, rx_data_o}), 32'd0);
            end else begin
               exp_r = rq.pop_front();
               check_eq("rx_data", 32'(rx_data_o), 32'(exp_r));
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk_10MHz);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      tx_data_i  = b;
      tx_valid_i = 1'b1;
      while (n < 300) begin
         @(negedge clk_10MHz);
         if (tx_ready_o) break;
         n++;
      end
      check_eq("tx_accept_in_time", 32'(n < 300), 32'd1);
      tick();
      tx_valid_i = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((wq.size() != 0 || rq.size() != 0) && n < 2000) begin
         @(negedge clk_10MHz);
         n++;
      end
      check_eq("drain", 32'(wq.size() + rq.size()), 32'd0);
   endtask

   task automatic wait_rx_valid();
      int n = 0;
      while (!rx_valid_o && n < 500) begin
         @(negedge clk_10MHz);
         n++;
      end
      check_eq("rx_valid_in_time", 32'(rx_valid_o), 32'd1);
   endtask

   task automatic do_reset(input string tag);
      tick();
      rst        = 1'b0;
      tx_valid_i = 1'b0;
      wq.delete();
      rq.delete();
      saw_send_wr = 1'b0;
      @(posedge clk_10MHz);
      @(negedge clk_10MHz);
      check_eq(tag, 32'(outs()), 32'd0);
      tick();
      rst = 1'b1;
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int n;
      logic [7:0] held;

      rst        = 1'b0;
      tx_data_i  = 8'h00;
      tx_valid_i = 1'b0;
      rx_ready_i = 1'b1;
      stuck      = 1'b0;
      loopback   = 1'b0;
      inj_req    = 1'b0;
      inj_byte   = 8'h00;

      // Reset held for three cycles, then released.
      repeat (3) @(posedge clk_10MHz);
      @(negedge clk_10MHz);
      check_eq("reset_outputs", 32'(outs()), 32'd0);
      tick();
      rst = 1'b1;

      n = 0;
      while (!tx_ready_o && n < 20) begin
         @(negedge clk_10MHz);
         n++;
      end
      check_eq("first_ready_latency_ok", 32'(tx_ready_o && n <= POLL_GAP + 2), 32'd1);
      @(negedge clk_10MHz);
      check_eq("ready_one_cycle", 32'(tx_ready_o), 32'd0);

      // Plain transmit: data write, send write, then polls only.
      loopback = 1'b0;
      send_byte(8'hAA);
      wait_drain();
      repeat (80) @(negedge clk_10MHz);
      check_eq("tx_only_uart_idle", 32'({u_send, u_new_rx, u_d0}), 32'h0AA);

      // Loopback: two bytes come back in order.
      loopback = 1'b1;
      send_byte(8'hAA);
      send_byte(8'h8C);
      wait_drain();
      repeat (4) @(negedge clk_10MHz);
      check_eq("uart_ctrl_cleared", 32'({u_send, u_new_rx}), 32'd0);
      check_eq("uart_rx_reg_last", 32'(u_d1), 32'h8C);

      // Byte arriving at the UART with no transmit in flight.
      tick();
      inj_byte = 8'h5A;
      rq.push_back(8'h5A);
      wq.push_back(10'h000);
      inj_req = 1'b1;
      tick();
      inj_req = 1'b0;
      wait_drain();

      // Consumer stalls for 100 cycles during PUSH_RX.
      rx_ready_i = 1'b0;
      send_byte(8'h96);
      wait_rx_valid();
      held = rx_data_o;
      check_eq("stall_data", 32'(held), 32'h96);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_10MHz);
         check_eq("stall_valid", 32'({rx_valid_o, rx_data_o}), 32'({1'b1, held}));
      end
      tick();
      rx_ready_i = 1'b1;
      @(negedge clk_10MHz);
      @(negedge clk_10MHz);
      check_eq("valid_drops_after_ready", 32'(rx_valid_o), 32'd0);
      wait_drain();

      // Send never completes: timeout after TIMEOUT_CYC cycles in WAIT_SEND.
      // WR_SEND is cycle k, the counter reads 0 at k+1 and TIMEOUT_CYC at
      // k+1+TIMEOUT_CYC, so the registered flag is visible at k+2+TIMEOUT_CYC.
      stuck       = 1'b1;
      loopback    = 1'b0;
      saw_send_wr = 1'b0;
      send_byte(8'hC3);
      n = 0;
      while (!timeout_o && n < 400) begin
         @(negedge clk_10MHz);
         n++;
      end
      check_eq("timeout_set", 32'(timeout_o), 32'd1);
      check_eq("timeout_latency", cyc - last_send_cyc, 32'(TIMEOUT_CYC + 2));
      repeat (20) @(negedge clk_10MHz);
      check_eq("timeout_no_ready_while_busy", 32'({tx_ready_o, rx_valid_o}), 32'd0);
      tick();
      stuck = 1'b0;
      repeat (10) @(negedge clk_10MHz);
      loopback = 1'b1;
      send_byte(8'h3C);
      wait_drain();
      check_eq("timeout_sticky", 32'(timeout_o), 32'd1);

      // Reset in the middle of WAIT_SEND.
      saw_send_wr = 1'b0;
      send_byte(8'h11);
      n = 0;
      while (!saw_send_wr && n < 50) begin
         @(negedge clk_10MHz);
         n++;
      end
      check_eq("send_write_seen", 32'(saw_send_wr), 32'd1);
      repeat (5) tick();
      do_reset("rst_wait_send");

      // Reset in the middle of PUSH_RX.
      rx_ready_i = 1'b0;
      send_byte(8'h22);
      wait_rx_valid();
      do_reset("rst_push_rx");
      rx_ready_i = 1'b1;

      // Fresh transfer after reset.
      send_byte(8'h55);
      wait_drain();
      check_eq("timeout_cleared_by_rst", 32'(timeout_o), 32'd0);
      repeat (5) @(negedge clk_10MHz);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #8000000;
      $display("FAIL watchdog got=stuck exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
